// File: rtl/toeplitz_hash_acc.sv
// Toeplitz hash accumulator: requests a seed pass from the shifter, then XORs one seed row
// into the hash for every raw-key bit popped from an FWFT FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; acc held at zero, last hash kept on hash_out
// REQ   | shift_en high until the shifter acknowledges seed capture
// ARM   | seed captured, waiting for the row stream to begin
// ACC   | one row per cycle while the delayed sum_en is high
// DONE  | hash presented with hash_valid until hash_ready
module toeplitz_hash_acc #(
   parameter int ROW_W = 3072,
   parameter int CNT_W = 13
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   output logic             shift_en,
   input  logic             shift_ack,
   input  logic             sum_en,
   input  logic [ROW_W-1:0] shift_result,
   input  logic             raw_bit,
   input  logic             raw_empty,
   output logic             raw_rd_en,
   output logic [ROW_W-1:0] hash_out,
   output logic             hash_valid,
   input  logic             hash_ready,
   output logic             busy,
   output logic [CNT_W-1:0] row_cnt,
   output logic             underflow
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_ARM  = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   acc_q, acc_d;
   logic [ROW_W-1:0]   hash_q, hash_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               uf_q, uf_d;
   logic               sum_dly_q, sum_dly_d;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         hash_q    <= '0;
         cnt_q     <= '0;
         uf_q      <= 1'b0;
         sum_dly_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         hash_q    <= hash_d;
         cnt_q     <= cnt_d;
         uf_q      <= uf_d;
         sum_dly_q <= sum_dly_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      hash_d     = hash_q;
      cnt_d      = cnt_q;
      uf_d       = uf_q;
      sum_dly_d  = sum_en;
      shift_en   = 1'b0;
      raw_rd_en  = 1'b0;
      hash_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            acc_d = '0;
            // Clear on the way into REQ so the first REQ cycle already shows a fresh block.
            if (start) begin
               state_d = S_REQ;
               cnt_d   = '0;
               uf_d    = 1'b0;
            end
         end
         S_REQ: begin
            shift_en = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            uf_d     = 1'b0;
            if (shift_ack) state_d = S_ARM;
         end
         S_ARM: begin
            if (sum_en) state_d = S_ACC;
         end
         S_ACC: begin
            if (sum_dly_q) begin
               raw_rd_en = ~raw_empty;
               if (raw_bit && !raw_empty) acc_d = acc_q ^ shift_result;
               if (raw_empty) uf_d = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               // sum_en falling marks the final row; it is folded in on this same edge.
               if (!sum_en) begin
                  state_d = S_DONE;
                  hash_d  = acc_d;
               end
            end
         end
         S_DONE: begin
            hash_valid = 1'b1;
            if (hash_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign hash_out  = hash_q;
   assign row_cnt   = cnt_q;
   assign underflow = uf_q;

endmodule

// File: tb/tb_toeplitz_hash_acc.sv
// Bench for toeplitz_hash_acc: shifter and FWFT FIFO models drive passes, a reference model
// computes each hash as a plain XOR over the selected rows, and a monitor checks every result.
module tb_toeplitz_hash_acc;
   localparam int RW = 8;
   localparam int CW = 13;
   localparam int MAXR = 8200;

   logic          clk_in, rst, start, shift_en, shift_ack, sum_en;
   logic [RW-1:0] shift_result, hash_out;
   logic          raw_bit, raw_empty, raw_rd_en, hash_valid, hash_ready, busy, underflow;
   logic [CW-1:0] row_cnt;

   toeplitz_hash_acc #(.ROW_W(RW), .CNT_W(CW)) dut (
      .clk_in(clk_in), .rst(rst), .start(start), .shift_en(shift_en), .shift_ack(shift_ack),
      .sum_en(sum_en), .shift_result(shift_result), .raw_bit(raw_bit), .raw_empty(raw_empty),
      .raw_rd_en(raw_rd_en), .hash_out(hash_out), .hash_valid(hash_valid),
      .hash_ready(hash_ready), .busy(busy), .row_cnt(row_cnt), .underflow(underflow)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [RW-1:0] h;
      logic [CW-1:0] c;
      logic          u;
   } exp_t;

   exp_t          sbq[$];
   bit            fifo[$];
   logic [RW-1:0] rows [0:MAXR-1];
   bit            bits [0:MAXR-1];
   int            total = 0;
   int            bad = 0;
   int            rd_total = 0;
   int            rd_consumed = 0;

   always @(posedge clk_in) if (raw_rd_en) rd_total <= rd_total + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Pops seen at the last edge are applied here; an empty FIFO shows raw_bit=1 so that
   // the raw_empty gating of the data bit is exercised.
   task automatic fifo_sync();
      while (rd_consumed < rd_total) begin
         if (fifo.size() > 0) void'(fifo.pop_front());
         rd_consumed++;
      end
      raw_empty = (fifo.size() == 0);
      raw_bit   = raw_empty ? 1'b1 : fifo[0];
   endtask

   task automatic tick();
      @(negedge clk_in);
      fifo_sync();
   endtask

   function automatic exp_t model(input int n, input int ga, input int gl);
      exp_t e;
      e.h = '0;
      for (int k = 0; k < n; k++)
         if (bits[k] && !(k >= ga && k < ga + gl)) e.h = e.h ^ rows[k];
      e.c = CW'(n % (1 << CW));
      e.u = (gl > 0) && (ga < n);
      return e;
   endfunction

   task automatic fill_lfsr(input int n);
      logic [RW-1:0] s;
      s = 8'hA5;
      for (int k = 0; k < n; k++) begin
         rows[k] = s;
         s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
      end
   endtask

   task automatic fill_rand(input int n);
      for (int k = 0; k < n; k++) rows[k] = RW'($urandom);
   endtask

   task automatic fill_bits(input int n, input int mode);
      for (int k = 0; k < n; k++)
         bits[k] = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom);
   endtask

   task automatic monitor();
      bit   prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (hash_valid && !prev && !rst) begin
            if (sbq.size() == 0) begin
               chk("unexpected_hash", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("hash", hash_out, e.h);
               chk("row_cnt", row_cnt, e.c);
               chk("underflow", underflow, e.u);
            end
         end
         prev = hash_valid;
      end
   endtask

   task automatic do_pass(input int n, input int ga, input int gl, input bit ready_early,
                          input int abort_row);
      exp_t e;
      int   rd0, ngap;
      e = model(n, ga, gl);
      ngap = 0;
      for (int k = 0; k < n; k++) if (k >= ga && k < ga + gl) ngap++;
      if (abort_row < 0) sbq.push_back(e);
      hash_ready = ready_early;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("req_shift_en", shift_en, 1);
      chk("req_busy", busy, 1);
      shift_ack = 1'b1;
      tick();
      shift_ack = 1'b0;
      chk("arm_shift_en", shift_en, 0);
      chk("arm_uf_cnt", {underflow, row_cnt}, 0);
      tick();
      rd0 = rd_total;
      for (int i = 0; i <= n; i++) begin
         if (i == abort_row) begin
            rst = 1'b1;
            #1;
            chk("abort_outs", {shift_en, raw_rd_en, hash_valid, busy, underflow, row_cnt, hash_out}, 0);
            sum_en = 1'b0;
            shift_result = '0;
            tick();
            tick();
            rst = 1'b0;
            fifo.delete();
            fifo_sync();
            tick();
            return;
         end
         if (i > 0 && !((i - 1) >= ga && (i - 1) < ga + gl)) fifo.push_back(bits[i-1]);
         sum_en = (i < n);
         shift_result = (i > 0) ? rows[i-1] : '0;
         fifo_sync();
         tick();
      end
      sum_en = 1'b0;
      shift_result = '0;
      chk("done_valid", hash_valid, 1);
      chk("rd_pulses", rd_total - rd0, n - ngap);
      if (ready_early) begin
         tick();
         chk("idle_after", {hash_valid, busy}, 0);
      end else begin
         for (int j = 0; j < 20; j++) begin
            start = 1'b1;
            chk("hold_hash", hash_out, e.h);
            chk("hold_busy_valid", {busy, hash_valid}, 2'b11);
            tick();
         end
         start = 1'b0;
         hash_ready = 1'b1;
         tick();
         chk("idle_after_ready", {hash_valid, busy}, 0);
         chk("hash_held", hash_out, e.h);
      end
   endtask

   initial begin
      int rd0, n;
      rst = 1'b1; start = 1'b0; shift_ack = 1'b0; sum_en = 1'b0; shift_result = '0;
      hash_ready = 1'b0; raw_bit = 1'b0; raw_empty = 1'b1;
      fork
         monitor();
      join_none
      tick();
      tick();
      chk("reset_outs", {shift_en, raw_rd_en, hash_out, hash_valid, busy, row_cnt, underflow}, 0);
      rst = 1'b0;
      tick();

      fill_lfsr(4097); fill_bits(4097, 0);
      do_pass(4097, -1, 0, 1'b1, -1);
      fill_bits(4097, 1);
      do_pass(4097, -1, 0, 1'b1, -1);
      fill_bits(4097, 2);
      do_pass(4097, 100, 5, 1'b1, -1);
      tick(); tick();
      chk("uf_sticky", underflow, 1);

      fill_rand(50); fill_bits(50, 2);
      do_pass(50, -1, 0, 1'b0, -1);

      fill_lfsr(4097); fill_bits(4097, 2);
      do_pass(4097, -1, 0, 1'b1, 2000);
      do_pass(4097, -1, 0, 1'b1, -1);

      rd0 = rd_total;
      fifo.push_back(1'b1);
      for (int j = 0; j < 4; j++) begin
         shift_ack = (j % 2 == 0);
         sum_en = 1'b1;
         shift_result = 8'hFF;
         fifo_sync();
         #1;
         chk("spurious_idle", {shift_en, raw_rd_en, busy, hash_valid}, 0);
         tick();
      end
      shift_ack = 1'b0; sum_en = 1'b0; shift_result = '0;
      tick();
      chk("spurious_nopop", rd_total - rd0, 0);
      fifo.delete();
      fifo_sync();
      fill_rand(10); fill_bits(10, 2);
      do_pass(10, -1, 0, 1'b1, -1);

      fill_rand(1); fill_bits(1, 0);
      do_pass(1, -1, 0, 1'b1, -1);
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(2, 30);
         fill_rand(n); fill_bits(n, 2);
         do_pass(n, -1, 0, 1'b1, -1);
      end

      fill_rand(8195); fill_bits(8195, 2);
      do_pass(8195, -1, 0, 1'b1, -1);

      tick(); tick(); tick();
      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/toeplitz_hash_acc.md
# toeplitz_hash_acc

Consumer end of the seed-shift interface in the Toeplitz hashing path. Requests a seed pass from the shifter, then XOR-accumulates one shifted seed row per raw-key bit, where each raw bit comes from a first-word-fall-through FIFO. The result is a ROW_W-bit hash block, presented downstream with a valid/ready handshake. One instance pairs with one shifter; the hash is the Toeplitz matrix–vector product over GF(2).

## Interface
- ROW_W, 3072: row and hash width in bits.
- CNT_W, 13: width of the row counter.
- clk_in  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request one hash block; sampled only in IDLE.
- shift_en  out  1  request to the shifter; held high until shift_ack is seen.
- shift_ack  in  1  one-cycle pulse from the shifter: the seed has been captured.
- sum_en  in  1  shifter row-stream enable.
- shift_result  in  ROW_W  current seed row.
- raw_bit  in  1  FWFT FIFO head data; valid when raw_empty=0.
- raw_empty  in  1  FIFO empty flag.
- raw_rd_en  out  1  FIFO pop strobe (combinational).
- hash_out  out  ROW_W  accumulated hash; stable while hash_valid=1.
- hash_valid  out  1  hash available.
- hash_ready  in  1  downstream accepts the hash.
- busy  out  1  high in every state except IDLE.
- row_cnt  out  CNT_W  rows consumed in the current or last block.
- underflow  out  1  sticky flag: a row arrived while raw_empty=1. Cleared only by rst or by entering REQ.

## Operation
- Row-valid qualifier: sum_d is sum_en registered by one cycle. row_vld = sum_d in state ACC. The shifter drives shift_result one cycle after sum_en, and its last row coincides with sum_en falling.
- States: IDLE, REQ, ARM, ACC, DONE.
- IDLE:
  - acc=0, row_cnt held, hash_valid=0, shift_en=0.
  - start=1 → REQ.
- REQ:
  - shift_en=1, acc cleared, row_cnt cleared, underflow cleared.
  - shift_ack=1 → ARM, with shift_en=0 registered on the same edge.
- ARM: wait for sum_en=1, then → ACC.
- ACC:
  - Each cycle with row_vld=1:
    - acc ← acc XOR (raw_bit_eff ? shift_result : 0), where raw_bit_eff = raw_bit & ~raw_empty.
    - row_cnt ← row_cnt+1.
    - raw_rd_en = ~raw_empty.
    - If raw_empty=1, set underflow.
  - When sum_d=1 and sum_en=0, that cycle's row is the last one. Accumulate it, and on the same edge → DONE.
- DONE:
  - hash_out=acc, hash_valid=1.
  - When hash_ready=1: hash_valid←0 → IDLE. hash_out holds its value.
- Arithmetic:
  - XOR only, no carries.
  - row_cnt wraps modulo 2^CNT_W without a flag; the normal pass of 4097 rows fits in 13 bits.
- Ignored inputs:
  - shift_ack outside REQ.
  - start outside IDLE.
  - sum_en in IDLE, REQ and DONE.
- raw_rd_en is 0 outside ACC. Raw bits are never popped in any other state.

## Timing
- Reset values: shift_en=0, raw_rd_en=0, hash_out=0, hash_valid=0, busy=0, row_cnt=0, underflow=0; state=IDLE, acc=0, sum_d=0.
- rst mid-pass:
  - All outputs return to their reset values immediately.
  - The FIFO is not drained.
  - The shifter is reset by the same rst.
- start=1 at edge t: REQ from t+1, so shift_en=1 in cycle t+1.
- shift_ack seen at edge a: shift_en=0 from a+1.
- First row_vld occurs one cycle after the first sum_en=1 cycle.
- Latency from the last row to hash_valid: 1 cycle.
- Throughput: one row per clock, with no back-pressure toward the shifter. The FIFO must stay non-empty during ACC, otherwise underflow is set.
- hash_ready already high when hash_valid rises: the transfer takes 1 cycle, and IDLE follows on the next edge.
- Back-to-back blocks: start held high re-enters REQ one cycle after IDLE, giving at least 2 idle-side cycles per block.

## Test plan
- ROW_W=8, CNT_W=13, shifter model with seed 8'hA5 and shift_bit=0, 4097 rows, raw bits all 1 → hash = XOR of all rows, compared against a software model; row_cnt=4097; underflow=0.
- Same setup with raw bits alternating 1,0,1,0… → hash equals the model's result over the even-index rows only; raw_rd_en pulses exactly 4097 times.
- FIFO empties after 100 rows and is refilled 5 cycles later → underflow=1; the 5 missing bits count as 0; hash matches the model; underflow persists until the next start.
- hash_ready held low for 20 cycles after hash_valid → hash_out stable, busy=1, start ignored; hash_ready=1 → IDLE next cycle.
- rst asserted on row 2000 → all outputs are 0 asynchronously; a fresh start then gives row_cnt=4097 and the correct hash.
- Spurious shift_ack and sum_en pulses in IDLE → no state change, raw_rd_en=0, acc stays 0.
